// File: rtl/reg_rd_stream_pkg.sv
// Shared widths and FSM encoding for the register-file read sequencer.
//   WIDTH       register word width (matches the 16-bit per-thread reg file)
//   N_THREADS   threads sharing the register file
//   THREAD_W    width of a thread number
//   REG_ADDR_W  width of a register index (16 registers per thread)
//   RD_LEN_W    width of a burst length-minus-one field
package reg_rd_stream_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned N_THREADS  = 8;
    localparam int unsigned THREAD_W   = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned RD_LEN_W   = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/reg_rd_stream.sv
// Read sequencer driving the read port of the per-thread register file BRAM.
// Accepts a burst request (thread, start register, length-1), issues the
// two-stage read enables with stall-safe valid tracking and presents the
// register file output FF directly as a valid/ready stream with 'last'.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             burst request handshake
//   req_thread/req_addr/req_len_m1  burst thread, first register, length-1
//   rd_thread_num/rd_addr           register file read address
//   rd_en0                          BRAM read enable (stage 0)
//   rd_en1                          register file output FF enable (stage 1)
//   reg_dout                        register file read data
//   out_valid/out_ready             output word handshake
//   out_data/out_last               output word (= reg_dout), final-word flag
//   busy                            burst issuing or words in flight
module reg_rd_stream
    import reg_rd_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [THREAD_W-1:0]   req_thread,
    input  logic [REG_ADDR_W-1:0] req_addr,
    input  logic [RD_LEN_W-1:0]   req_len_m1,
    output logic [THREAD_W-1:0]   rd_thread_num,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_en0,
    output logic                  rd_en1,
    input  logic [WIDTH-1:0]      reg_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy
);

    state_t                state;
    logic [THREAD_W-1:0]   thread_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [RD_LEN_W-1:0]   cnt_q;
    logic                  v0, v1;   // word in BRAM output reg / reg file output FF
    logic                  l0, l1;   // 'last' flag riding with each stage
    logic                  final_issue;
    logic                  accept;

    // Pipeline advance: stage 1 loads when it is empty or draining; stage 0
    // issues only when its slot frees up, so at most two words are in flight.
    always_comb begin
        rd_en1      = v0 & (~v1 | out_ready);
        rd_en0      = (state == S_ISSUE) & (~v0 | rd_en1);
        final_issue = rd_en0 & (cnt_q == '0);
        req_ready   = (state == S_IDLE) | final_issue;
        accept      = req_valid & req_ready;
    end

    // Burst FSM and address/count tracking; a request accepted on the final
    // issue cycle reloads the burst so back-to-back bursts have no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            thread_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_ISSUE;
                        thread_q <= req_thread;
                        addr_q   <= req_addr;
                        cnt_q    <= req_len_m1;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        thread_q <= req_thread;
                        addr_q   <= req_addr;
                        cnt_q    <= req_len_m1;
                    end else if (rd_en0) begin
                        addr_q <= addr_q + REG_ADDR_W'(1);
                        cnt_q  <= cnt_q - RD_LEN_W'(1);
                        if (cnt_q == '0) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid and last flags for the two read stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            l0 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            v0 <= rd_en0 | (v0 & ~rd_en1);
            v1 <= rd_en1 | (v1 & ~out_ready);
            if (rd_en0) begin
                l0 <= (cnt_q == '0);
            end
            if (rd_en1) begin
                l1 <= l0;
            end
        end
    end

    assign rd_thread_num = thread_q;
    assign rd_addr       = addr_q;
    assign out_valid     = v1;
    assign out_data      = reg_dout;
    assign out_last      = v1 & l1;
    assign busy          = (state == S_ISSUE) | v0 | v1;

endmodule

// File: tb/tb_reg_rd_stream.sv
// Directed testbench for reg_rd_stream with a behavioural two-stage register
// file model and a scoreboard of expected output words.
module tb_reg_rd_stream;
    import reg_rd_stream_pkg::*;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic [THREAD_W-1:0]   req_thread;
    logic [REG_ADDR_W-1:0] req_addr;
    logic [RD_LEN_W-1:0]   req_len_m1;
    logic [THREAD_W-1:0]   rd_thread_num;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_en0;
    logic                  rd_en1;
    logic [WIDTH-1:0]      reg_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;
    int inflight = 0;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] mem [N_THREADS*16];
    logic [WIDTH-1:0] bram_q;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;

    reg_rd_stream dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_thread    (req_thread),
        .req_addr      (req_addr),
        .req_len_m1    (req_len_m1),
        .rd_thread_num (rd_thread_num),
        .rd_addr       (rd_addr),
        .rd_en0        (rd_en0),
        .rd_en1        (rd_en1),
        .reg_dout      (reg_dout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] word_of(input int idx);
        return WIDTH'(idx * 257 + 16'h3C05);
    endfunction

    // Register file model: BRAM read on rd_en0, output FF load on rd_en1.
    always @(posedge clk) begin
        if (rd_en0) bram_q <= mem[{rd_thread_num, rd_addr}];
        if (rd_en1) reg_dout <= bram_q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int thr, input int addr, input int len_m1);
        exp_t e;
        for (int k = 0; k <= len_m1; k++) begin
            e.data = word_of(thr * 16 + ((addr + k) % 16));
            e.last = (k == len_m1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor, output stability and in-flight bound.
    always @(negedge clk) begin
        if (rst) begin
            inflight   = 0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (inflight == 2 && !out_ready) begin
                chk("rd_en0_full_stall", 32'(rd_en0), 32'd0);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                n_popped++;
            end
            inflight = inflight + int'(rd_en0) - int'(out_valid && out_ready);
            if (rd_en0) chk("inflight_le2", 32'(inflight <= 2), 32'd1);
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Present a request and hold it until accepted; returns just after the
    // accepting edge.
    task automatic send_req(input int thr, input int addr, input int len_m1);
        int w;
        w = 0;
        push_burst(thr, addr, len_m1);
        req_valid  = 1'b1;
        req_thread = THREAD_W'(thr);
        req_addr   = REG_ADDR_W'(addr);
        req_len_m1 = RD_LEN_W'(len_m1);
        @(negedge clk);
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input bit toggle);
        int w;
        logic [4:0] pat;
        w   = 0;
        pat = 5'b01001;
        while ((busy || exp_q.size() != 0) && w < 300) begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = pat[w % 5];
            w++;
        end
        out_ready = 1'b1;
        chk(tag, 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        int base;
        int w;
        bit seen;
        for (int i = 0; i < N_THREADS * 16; i++) mem[i] = word_of(i);
        bram_q     = '0;
        reg_dout   = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        req_valid  = 1'b0;
        req_thread = '0;
        req_addr   = '0;
        req_len_m1 = '0;
        out_ready  = 1'b1;
        rst        = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_rd_en0", 32'(rd_en0), 32'd0);
        chk("rst_rd_en1", 32'(rd_en1), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: full 16-word burst from thread 2, latency of three cycles
        send_req(2, 0, 15);
        @(negedge clk);
        chk("t1_rd_en0_T1", 32'(rd_en0), 32'd1);
        chk("t1_rd_addr_T1", 32'(rd_addr), 32'd0);
        chk("t1_thread_T1", 32'(rd_thread_num), 32'd2);
        chk("t1_valid_T1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_rd_en1_T2", 32'(rd_en1), 32'd1);
        chk("t1_rd_addr_T2", 32'(rd_addr), 32'd1);
        chk("t1_valid_T2", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_T3", 32'(out_valid), 32'd1);
        chk("t1_first_word", 32'(out_data), 32'(word_of(32)));
        #1;
        drain("t1_drain", 1'b0);

        // 2: address wrap 14,15,0,1 within thread 5
        send_req(5, 14, 3);
        drain("t2_drain", 1'b0);

        // 3: 8 words under toggling backpressure
        base = n_popped;
        send_req(1, 4, 7);
        drain("t3_drain", 1'b1);
        chk("t3_word_count", 32'(n_popped - base), 32'd8);

        // 4: back-to-back requests with no issue bubble
        base = n_popped;
        push_burst(3, 9, 0);
        push_burst(6, 2, 1);
        req_valid  = 1'b1;
        req_thread = THREAD_W'(3);
        req_addr   = REG_ADDR_W'(9);
        req_len_m1 = RD_LEN_W'(0);
        @(negedge clk);
        chk("t4_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_thread = THREAD_W'(6);
        req_addr   = REG_ADDR_W'(2);
        req_len_m1 = RD_LEN_W'(1);
        @(negedge clk);
        chk("t4_rd_en0_a", 32'(rd_en0), 32'd1);
        chk("t4_ready_final", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t4_rd_en0_b0", 32'(rd_en0), 32'd1);
        chk("t4_rd_addr_b0", 32'(rd_addr), 32'd2);
        chk("t4_thread_b0", 32'(rd_thread_num), 32'd6);
        @(negedge clk);
        chk("t4_rd_en0_b1", 32'(rd_en0), 32'd1);
        #1;
        drain("t4_drain", 1'b0);
        chk("t4_word_count", 32'(n_popped - base), 32'd3);

        // 5: reset in the middle of an 8-word burst
        base = n_popped;
        send_req(0, 3, 7);
        w = 0;
        while (n_popped - base < 3 && w < 50) begin
            @(posedge clk);
            w++;
        end
        chk("t5_three_words", 32'(n_popped - base), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_rd_en0", 32'(rd_en0), 32'd0);
        chk("t5_rst_rd_en1", 32'(rd_en1), 32'd0);
        chk("t5_rst_last", 32'(out_last), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("t5_no_stale", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        // 6: single word held under 10 cycles of backpressure
        out_ready = 1'b0;
        send_req(4, 7, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_last", 32'(out_last), 32'd1);
        chk("t6_data", 32'(out_data), 32'(word_of(4 * 16 + 7)));
        chk("t6_rd_en0", 32'(rd_en0), 32'd0);
        out_ready = 1'b1;
        drain("t6_drain", 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
